// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    HOLD      = 3'd1,
    LOAD      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte-stream bus: one valid/data/last/ready slice per requester.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import uart_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [UART_BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set req bit at or above ptr, modulo N.
module rr_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % N;
    return IW'(s);
  endfunction

  // Scan from ptr upward and keep the first requester found.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!grant_any && req[wrap_idx(ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; a winner keeps it until its 'last' byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_arbiter_if.slave         req_if,
  output logic                     uart_start,
  output logic [UART_BYTE_W-1:0]   uart_byte,
  input  logic                     uart_busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     owner_valid,
  output logic                     ack_err
);

  localparam int unsigned   OW       = $clog2(N_REQ);
  localparam int unsigned   CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [OW-1:0] OWN_LAST = OW'(N_REQ - 1);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [OW-1:0]          r_ptr;
  logic [OW-1:0]          w_ptr_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_last;
  logic                   w_last_nxt;
  logic [UART_BYTE_W-1:0] w_byte_nxt;
  logic [OW-1:0]          w_owner_nxt;
  logic                   w_owner_valid_nxt;
  logic                   w_start_nxt;
  logic                   w_ack_err_nxt;
  logic                   w_end_byte;

  logic [OW-1:0]          w_grant_idx;
  logic                   w_grant_any;
  logic [N_REQ-1:0]       w_ready;
  logic [OW-1:0]          w_sel;
  logic                   w_accept;
  logic [UART_BYTE_W-1:0] w_sel_byte;
  logic                   w_sel_last;

  rr_picker #(
    .N (N_REQ)
  ) u_picker (
    .req       (req_if.req_valid),
    .ptr       (r_ptr),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  // Ready goes to the round-robin winner when idle, to the owner while locked.
  always_comb begin
    w_ready = '0;
    w_sel   = owner;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_state == ARB) begin
        w_ready[i] = w_grant_any && (w_grant_idx == OW'(i));
      end else if (r_state == HOLD) begin
        w_ready[i] = (owner == OW'(i));
      end
    end
    if (r_state == ARB) begin
      w_sel = w_grant_idx;
    end
    w_accept = |(w_ready & req_if.req_valid);
  end

  assign req_if.req_ready = w_ready;

  // Payload of the selected requester.
  always_comb begin
    w_sel_byte = '0;
    w_sel_last = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_sel == OW'(i)) begin
        w_sel_byte = req_if.req_data[i*UART_BYTE_W +: UART_BYTE_W];
        w_sel_last = req_if.req_last[i];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_last_nxt        = r_last;
    w_byte_nxt        = uart_byte;
    w_owner_nxt       = owner;
    w_owner_valid_nxt = owner_valid;
    w_start_nxt       = 1'b0;
    w_ack_err_nxt     = 1'b0;
    w_end_byte        = 1'b0;

    case (r_state)
      ARB, HOLD: begin
        if (w_accept) begin
          w_byte_nxt        = w_sel_byte;
          w_last_nxt        = w_sel_last;
          w_owner_nxt       = w_sel;
          w_owner_valid_nxt = 1'b1;
          w_state_nxt       = LOAD;
        end
      end
      LOAD: begin
        // Wait out any frame still draining before starting ours.
        if (!uart_busy) begin
          w_start_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (uart_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_ack_err_nxt = 1'b1;
          w_end_byte    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          w_end_byte = 1'b1;
        end
      end
      default: w_state_nxt = ARB;
    endcase

    // A 'last' byte releases the lock and advances the round-robin pointer.
    if (w_end_byte) begin
      if (r_last) begin
        w_ptr_nxt         = (owner == OWN_LAST) ? '0 : owner + OW'(1);
        w_owner_valid_nxt = 1'b0;
        w_state_nxt       = ARB;
      end else begin
        w_state_nxt = HOLD;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      uart_start  <= 1'b0;
      uart_byte   <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      uart_start  <= w_start_nxt;
      uart_byte   <= w_byte_nxt;
      owner       <= w_owner_nxt;
      owner_valid <= w_owner_valid_nxt;
      ack_err     <= w_ack_err_nxt;
    end
  end

endmodule
